// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO reader/writer sides: default word width,
// stream handshake type, skid-buffer occupancy states and the pop credit check.
package fifo_pkg;

  localparam int DEF_WIDTH = 8;

  typedef struct packed {
    logic                 valid;
    logic [DEF_WIDTH-1:0] data;
  } stream_t;

  typedef enum logic [1:0] {
    OCC_0 = 2'd0,
    OCC_1 = 2'd1,
    OCC_2 = 2'd2
  } occ_e;

  // The word leaving this cycle frees its slot, so it counts as spare credit.
  // Without it the reader would stall every other cycle.
  function automatic logic credit_ok(input logic [1:0] occ, input logic inflight,
                                     input logic drain);
    logic [2:0] used;
    used = {1'b0, occ} + {2'b00, inflight};
    return (used < (3'd2 + {2'b00, drain}));
  endfunction

endpackage

// File: rtl/fifo_stream_reader_skid_buf2.sv
// Two-entry in-order skid buffer with valid/ready on both sides and an occupancy
// output. The head slot drives m_data and is cleared when the buffer empties.
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [1:0]       occ
);

  occ_e             occ_r;
  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] tail_r;
  logic             rd_s;
  logic             wr_s;

  assign m_valid = (occ_r != OCC_0);
  assign m_data  = head_r;
  assign occ     = occ_r;
  assign rd_s    = m_valid & m_ready;
  assign wr_s    = s_valid & ((occ_r != OCC_2) | rd_s);

  // Occupancy state machine with head/tail slot updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_r  <= OCC_0;
      head_r <= {WIDTH{1'b0}};
      tail_r <= {WIDTH{1'b0}};
    end else begin
      case (occ_r)
        OCC_0: begin
          if (wr_s) begin
            head_r <= s_data;
            occ_r  <= OCC_1;
          end
        end
        OCC_1: begin
          if (wr_s && rd_s) begin
            head_r <= s_data;
          end else if (wr_s) begin
            tail_r <= s_data;
            occ_r  <= OCC_2;
          end else if (rd_s) begin
            head_r <= {WIDTH{1'b0}};
            occ_r  <= OCC_0;
          end
        end
        OCC_2: begin
          if (rd_s) begin
            head_r <= tail_r;
            if (wr_s) begin
              tail_r <= s_data;
            end else begin
              occ_r <= OCC_1;
            end
          end
        end
        default: begin
          occ_r  <= OCC_0;
          head_r <= {WIDTH{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side controller for the push/pop FIFO: issues credit-limited pops, absorbs
// the FIFO's registered read latency and presents words as a valid/ready stream.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic             fifo_push,
  input  logic [WIDTH-1:0] fifo_out,
  output logic             fifo_pop,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             pop_collide,
  output logic [CNT_W-1:0] rd_count
);

  logic             inflight_r;
  logic             pop_collide_r;
  logic [CNT_W-1:0] rd_count_r;
  logic [1:0]       occ_s;
  logic             hs_s;
  logic             credit_s;

  assign hs_s        = m_valid & m_ready;
  assign credit_s    = credit_ok(occ_s, inflight_r, hs_s);
  // Never pop alongside a push: the FIFO would drop it and the inflight flag would lie.
  assign fifo_pop    = ~rst & ~fifo_empty & ~fifo_push & credit_s;
  assign pop_collide = pop_collide_r;
  assign rd_count    = rd_count_r;

  // Pop-in-flight tracking, writer collision flag and delivered-word count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_r    <= 1'b0;
      pop_collide_r <= 1'b0;
      rd_count_r    <= {CNT_W{1'b0}};
    end else begin
      inflight_r    <= fifo_pop;
      pop_collide_r <= ~fifo_empty & fifo_push & credit_s;
      if (hs_s) begin
        rd_count_r <= rd_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        rd_count_r <= rd_count_r;
      end
    end
  end

  skid_buf2 #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .s_valid (inflight_r),
    .s_data  (fifo_out),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .occ     (occ_s)
  );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: a behavioural push/pop FIFO feeds the DUT
// and a queue of pushed words is the expected in-order delivery.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic        fifo_push;
  logic [7:0]  fifo_out;
  logic        fifo_pop;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        pop_collide;
  logic [15:0] rd_count;
  logic [7:0]  push_data;

  logic [7:0]  mem [0:2047];
  int          wr_ptr;
  int          rd_ptr;
  logic [7:0]  exp_q [$];
  int          rd_idx = 0;
  int          n_assert = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  fifo_stream_reader #(.WIDTH(8), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_empty  (fifo_empty),
    .fifo_push   (fifo_push),
    .fifo_out    (fifo_out),
    .fifo_pop    (fifo_pop),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .pop_collide (pop_collide),
    .rd_count    (rd_count)
  );

  // Behavioural FIFO: registered read data, pop ignored when push is also high.
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= 0;
      rd_ptr   <= 0;
      fifo_out <= 8'h00;
    end else begin
      if (fifo_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1;
      end
      if (fifo_pop && !fifo_push && (wr_ptr != rd_ptr)) begin
        fifo_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, settle, score any handshake due at the next posedge.
  task automatic step(input logic rdy, input logic psh, input logic [7:0] pd);
    @(negedge clk);
    m_ready   = rdy;
    fifo_push = psh;
    push_data = pd;
    if (psh) exp_q.push_back(pd);
    #1;
    if (m_valid && m_ready) begin
      if (rd_idx < exp_q.size()) chk("m_data_order", {24'h0, m_data}, {24'h0, exp_q[rd_idx]});
      else chk("extra_word", rd_idx, exp_q.size());
      rd_idx++;
    end
  endtask

  initial begin
    int pushed;
    int cyc;
    logic psh;
    rst = 1'b1; m_ready = 1'b0; fifo_push = 1'b0; push_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_pop", fifo_pop, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_collide", pop_collide, 0);
    chk("rst_count", rd_count, 0);
    rst = 1'b0;

    // 1. reset while a pop is in flight
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h10 + 8'(i));
    step(1'b0, 1'b0, 8'h00);
    chk("t1_pop_issued", fifo_pop, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t1_rst_pop", fifo_pop, 0);
    chk("t1_rst_valid", m_valid, 0);
    chk("t1_rst_data", m_data, 0);
    chk("t1_rst_count", rd_count, 0);
    exp_q.delete();
    rd_idx = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 8'h00);
      chk("t1_no_stale", m_valid, 0);
    end
    chk("t1_count0", rd_count, 0);

    // 2. streaming A0..A6 at one word per clock
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 8'hA0 + 8'(i));
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'h00);
      chk("t2_pop", fifo_pop, (i < 7) ? 1 : 0);
      chk("t2_valid", m_valid, (i >= 2 && i < 9) ? 1 : 0);
    end
    chk("t2_count", rd_count, 7);

    // 3. backpressure with four words queued
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'hB0 + 8'(i));
    for (int j = 0; j < 6; j++) begin
      step(1'b0, 1'b0, 8'h00);
      chk("t3_pop", fifo_pop, (j < 2) ? 1 : 0);
      chk("t3_valid", m_valid, (j >= 2) ? 1 : 0);
      if (j >= 2) chk("t3_hold", m_data, 8'hB0);
    end
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b0, 8'h00);
      chk("t3_nogap", m_valid, (k < 4) ? 1 : 0);
    end
    chk("t3_count", rd_count, 11);

    // 4. writer pushing while the FIFO is non-empty
    step(1'b1, 1'b1, 8'hC0);
    for (int i = 1; i < 4; i++) begin
      step(1'b1, 1'b1, 8'hC0 + 8'(i));
      chk("t4_pop_blocked", fifo_pop, 0);
      chk("t4_collide", pop_collide, (i >= 2) ? 1 : 0);
    end
    step(1'b1, 1'b0, 8'h00);
    chk("t4_collide_last", pop_collide, 1);
    chk("t4_pop_resume", fifo_pop, 1);
    step(1'b1, 1'b0, 8'h00);
    chk("t4_collide_clr", pop_collide, 0);
    repeat (6) step(1'b1, 1'b0, 8'h00);
    chk("t4_no_loss", rd_idx, 15);
    chk("t4_count", rd_count, 15);

    // 5. single word drain to empty
    step(1'b1, 1'b1, 8'h5A);
    step(1'b1, 1'b0, 8'h00);
    chk("t5_pop", fifo_pop, 1);
    step(1'b1, 1'b0, 8'h00);
    chk("t5_pop_stop", fifo_pop, 0);
    step(1'b1, 1'b0, 8'h00);
    chk("t5_valid", m_valid, 1);
    chk("t5_data", m_data, 8'h5A);
    step(1'b1, 1'b0, 8'h00);
    chk("t5_valid_drop", m_valid, 0);
    chk("t5_idle_data", m_data, 0);
    chk("t5_pop_idle", fifo_pop, 0);
    chk("t5_count", rd_count, 16);

    // 6. random push / ready over 1000 words
    pushed = 0;
    cyc = 0;
    while ((pushed < 1000 || rd_idx < exp_q.size()) && cyc < 20000) begin
      psh = (pushed < 1000) && ($urandom_range(0, 1) == 1);
      step($urandom_range(0, 3) != 0, psh, 8'($urandom));
      if (psh) pushed++;
      cyc++;
    end
    chk("t6_bound", (cyc < 20000) ? 1 : 0, 1);
    step(1'b0, 1'b0, 8'h00);
    chk("t6_delivered", rd_idx, 1016);
    chk("t6_count", rd_count, 1016);
    chk("t6_idle", m_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
